axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 Parameter ADDR_W, 32, AXI-lite address width; SHALL match the connected axi_lite_if.
REQ-002 Parameter DATA_W, 32, data width, 32 or 64; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT, 256, cycles a single wait state may stall before the timeout flag asserts; minimum 2.
REQ-004 aclk  in  1  clock; all logic rising-edge.
REQ-005 areset_n  in  1  reset, synchronous, active-low.
REQ-006 m_axi_lite  axi_lite_if.master  --  AR/R/AW/W/B channels at ADDR_W/DATA_W.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data; ignored on reads.
REQ-012 cmd_wstrb  in  DATA_W/8  byte strobes; ignored on reads.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-016 rsp_resp  out  2  RRESP or BRESP of the transaction.
REQ-017 timeout  out  1  sticky stall flag.

Function
REQ-018 States SHALL be IDLE, RADDR, RDATA, WREQ, WRESP, RSP; one transaction outstanding at a time.
REQ-019 cmd_ready SHALL equal (state==IDLE); on acceptance, addr/wdata/wstrb/write SHALL be registered and state SHALL become RADDR (read) or WREQ (write).
REQ-020 In RADDR: arvalid=1, araddr=captured addr; on arvalid&arready go to RDATA.
REQ-021 In RDATA: rready=1; on rvalid&rready capture rdata and rresp, go to RSP.
REQ-022 In WREQ: awvalid and wvalid SHALL assert together in the first WREQ cycle; each SHALL drop independently after its own handshake; wstrb=captured cmd_wstrb.
REQ-023 WREQ SHALL exit to WRESP in the cycle after both AW and W have completed, whether in the same cycle or in either order.
REQ-024 In WRESP: bready=1; on bvalid&bready capture bresp, set rsp_rdata=0, go to RSP.
REQ-025 In RSP: rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready; on handshake go to IDLE.
REQ-026 Once asserted, a valid SHALL NOT drop before its ready handshake, including on timeout.
REQ-027 When not valid, araddr/awaddr/wdata SHALL be 0 and wstrb SHALL be 0.
REQ-028 Latency, zero-wait slave: cmd accepted at edge N; arvalid/awvalid/wvalid high in cycle N+1; read rsp_valid high in cycle N+3; write rsp_valid high in cycle N+4.
REQ-029 A stall counter SHALL reset on every state change; when it reaches TIMEOUT in RADDR, RDATA, WREQ or WRESP, timeout SHALL set and hold until the next command acceptance clears it.
REQ-030 The counter SHALL saturate, never wrap, and SHALL NOT count in IDLE or RSP.

Reset
REQ-031 While areset_n=0 at an edge: state=IDLE; all valid/ready outputs to m_axi_lite=0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; timeout=0; counter=0.
REQ-032 Reset mid-transaction SHALL drop all channel valids at that edge; the transaction is abandoned and no response is issued.
REQ-033 cmd_ready SHALL be 1 in the first cycle after areset_n rises.

Structure
REQ-034 The shared axi_lite_pkg SHALL hold the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR), the master state typedef, and the default width constants.
REQ-035 The stall counter SHALL be the sub-module axi_lite_stall_cnt (parameter TIMEOUT; inputs clear/enable; output hit).

Verification
REQ-036 Read 0x4, slave arready=1, rvalid with rdata 0xDEADBEEF and OKAY one cycle later -> rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_resp=0.
REQ-037 Write 0x10, data 0xCAFEF00D, wstrb 0xF; wready 3 cycles before awready -> wvalid drops first, single WRESP entry, wstrb=0xF on the bus.
REQ-038 Write with AW and W handshakes in the same cycle, bresp=SLVERR -> rsp_resp=2, rsp_rdata=0.
REQ-039 arready held low for 300 cycles with TIMEOUT=256 -> timeout=1 from stall cycle 256, arvalid still high; the next command acceptance clears timeout.
REQ-040 areset_n low in WREQ after AW completes -> awvalid=wvalid=0 at next edge, no rsp_valid, cmd_ready=1 after release.
REQ-041 rsp_ready held low 5 cycles with cmd_valid high -> rsp_* stable and cmd_ready=0 throughout.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, command-master states and default widths.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W        = 32;
  localparam int unsigned AXI_DATA_W        = 32;
  localparam int unsigned AXI_RESP_W        = 2;
  localparam int unsigned AXI_STALL_TIMEOUT = 256;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4,
    ST_RSP   = 3'd5
  } master_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bus bundle (AR/R/AW/W/B) with master and slave views.
interface axi_lite_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_stall_cnt.sv
// Saturating wait-state counter; hit_c flags the edge at which the count reaches TIMEOUT.
module axi_lite_stall_cnt #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_c
);

  localparam int unsigned       CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the count is at or about to reach the limit, so a sticky flag lands with it.
  assign hit_c = enable_i && !clear_i && (cnt_q >= (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-lite master: turns cmd_* requests into bus reads/writes and returns rsp_*.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = AXI_ADDR_W,
  parameter int unsigned DATA_W  = AXI_DATA_W,
  parameter int unsigned TIMEOUT = AXI_STALL_TIMEOUT
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  axi_lite_if.master            m_axi_lite,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [AXI_RESP_W-1:0] rsp_resp,
  output logic                  timeout
);

  localparam int unsigned STRB_W = DATA_W / 8;

  master_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic              bready_q, bready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  resp_t             rsp_resp_q, rsp_resp_d;
  logic              timeout_q, timeout_d;

  logic              cmd_accept;
  logic              stall_clear;
  logic              stall_enable;
  logic              stall_hit;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cmd_accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          wstrb_d    = cmd_wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = cmd_write ? ST_WREQ : ST_RADDR;
        end
      end
      ST_RADDR: begin
        if (arvalid_q && m_axi_lite.arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rready_q && m_axi_lite.rvalid) begin
          rsp_rdata_d = m_axi_lite.rdata;
          rsp_resp_d  = resp_t'(m_axi_lite.rresp);
          state_d     = ST_RSP;
        end
      end
      ST_WREQ: begin
        // Leave only once both halves were already complete, giving one idle WREQ cycle.
        if (aw_done_q && w_done_q) begin
          state_d = ST_WRESP;
        end else begin
          if (awvalid_q && m_axi_lite.awready) aw_done_d = 1'b1;
          if (wvalid_q && m_axi_lite.wready)   w_done_d  = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bready_q && m_axi_lite.bvalid) begin
          rsp_rdata_d = '0;
          rsp_resp_d  = resp_t'(m_axi_lite.bresp);
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    arvalid_d   = (state_d == ST_RADDR);
    araddr_d    = arvalid_d ? addr_d : '0;
    rready_d    = (state_d == ST_RDATA);
    awvalid_d   = (state_d == ST_WREQ) && !aw_done_d;
    awaddr_d    = awvalid_d ? addr_d : '0;
    wvalid_d    = (state_d == ST_WREQ) && !w_done_d;
    bus_wdata_d = wvalid_d ? wdata_d : '0;
    bus_wstrb_d = wvalid_d ? wstrb_d : '0;
    bready_d    = (state_d == ST_WRESP);
    rsp_valid_d = (state_d == ST_RSP);
    timeout_d   = cmd_accept ? 1'b0 : (timeout_q | stall_hit);
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
    end
  end

  // Wait-state watchdog restarts on every state change and idles outside bus phases.
  assign stall_clear  = (state_d != state_q);
  assign stall_enable = (state_q == ST_RADDR) || (state_q == ST_RDATA) ||
                        (state_q == ST_WREQ)  || (state_q == ST_WRESP);

  axi_lite_stall_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_cnt (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear_i  (stall_clear),
    .enable_i (stall_enable),
    .hit_c    (stall_hit)
  );

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign timeout            = timeout_q;
  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.araddr  = araddr_q;
  assign m_axi_lite.rready  = rready_q;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.awaddr  = awaddr_q;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.wdata   = bus_wdata_q;
  assign m_axi_lite.wstrb   = bus_wstrb_q;
  assign m_axi_lite.bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: scoreboard of expected responses plus cycle-level bus checks.
module tb_axi_lite_cmd_master;

  localparam int TO = 256;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic        aclk;
  logic        areset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  int   n_cmp = 0;
  int   n_err = 0;
  int   bready_cycles = 0;
  exp_t exp_q[$];
  exp_t exp_e;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_cmd_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .m_axi_lite (bus),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .timeout    (timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r);
    exp_q.push_back(exp_t'({d, r}));
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  // Response monitor: pops the scoreboard on every rsp handshake.
  always @(negedge aclk) begin
    if (bus.bready) bready_cycles++;
    if (areset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h resp %0d, expected no response", rsp_rdata, rsp_resp);
      end else begin
        exp_e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_e.rdata));
        check("rsp_resp",  64'(rsp_resp),  64'(exp_e.resp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;

    // Reset state
    repeat (3) next_cycle();
    mid();
    check("rst_arvalid",   64'(bus.arvalid), 64'(0));
    check("rst_awvalid",   64'(bus.awvalid), 64'(0));
    check("rst_wvalid",    64'(bus.wvalid),  64'(0));
    check("rst_rready",    64'(bus.rready),  64'(0));
    check("rst_bready",    64'(bus.bready),  64'(0));
    check("rst_rsp_valid", 64'(rsp_valid),   64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata),   64'(0));
    check("rst_rsp_resp",  64'(rsp_resp),    64'(0));
    check("rst_timeout",   64'(timeout),     64'(0));
    next_cycle(); areset_n = 1'b1;
    mid();
    check("rel_cmd_ready", 64'(cmd_ready), 64'(1));

    // Read 0x4 against a zero-wait slave: rsp_valid three cycles after acceptance
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; bus.arready = 1'b1; rsp_ready = 1'b1;
    push_exp(32'hDEADBEEF, 2'd0);
    next_cycle(); cmd_valid = 1'b0;
    mid();
    check("rd_arvalid",   64'(bus.arvalid), 64'(1));
    check("rd_araddr",    64'(bus.araddr),  64'(32'h4));
    check("rd_cmd_ready", 64'(cmd_ready),   64'(0));
    next_cycle(); bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF; bus.rresp = 2'd0;
    mid();
    check("rd_arvalid_drop", 64'(bus.arvalid), 64'(0));
    check("rd_araddr_zero",  64'(bus.araddr),  64'(0));
    check("rd_rready",       64'(bus.rready),  64'(1));
    next_cycle(); bus.rvalid = 1'b0; bus.rdata = '0;
    mid();
    check("rd_rsp_valid_n3", 64'(rsp_valid), 64'(1));
    next_cycle();
    mid();
    check("rd_rsp_done", 64'(rsp_valid), 64'(0));
    check("rd_idle",     64'(cmd_ready), 64'(1));

    // Write with AW and W in the same cycle, SLVERR response, rsp at N+4
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11223344; cmd_wstrb = 4'h3;
    bus.arready = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    push_exp(32'h0, 2'd2);
    next_cycle(); cmd_valid = 1'b0;
    mid();
    check("wr2_awvalid", 64'(bus.awvalid), 64'(1));
    check("wr2_wvalid",  64'(bus.wvalid),  64'(1));
    check("wr2_awaddr",  64'(bus.awaddr),  64'(32'h40));
    check("wr2_wdata",   64'(bus.wdata),   64'(32'h11223344));
    check("wr2_wstrb",   64'(bus.wstrb),   64'(4'h3));
    next_cycle(); bus.awready = 1'b0; bus.wready = 1'b0;
    mid();
    check("wr2_aw_drop",   64'(bus.awvalid), 64'(0));
    check("wr2_w_drop",    64'(bus.wvalid),  64'(0));
    check("wr2_no_bready", 64'(bus.bready),  64'(0));
    next_cycle(); bus.bvalid = 1'b1; bus.bresp = 2'd2;
    mid();
    check("wr2_bready", 64'(bus.bready), 64'(1));
    next_cycle(); bus.bvalid = 1'b0; bus.bresp = 2'd0;
    mid();
    check("wr2_rsp_valid_n4", 64'(rsp_valid), 64'(1));
    next_cycle();

    // Write 0x10 with W completing three cycles before AW
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    bus.awready = 1'b0; bus.wready = 1'b1; bready_cycles = 0;
    push_exp(32'h0, 2'd0);
    next_cycle(); cmd_valid = 1'b0;
    mid();
    check("wr1_awvalid", 64'(bus.awvalid), 64'(1));
    check("wr1_wvalid",  64'(bus.wvalid),  64'(1));
    check("wr1_awaddr",  64'(bus.awaddr),  64'(32'h10));
    check("wr1_wdata",   64'(bus.wdata),   64'(32'hCAFEF00D));
    check("wr1_wstrb",   64'(bus.wstrb),   64'(4'hF));
    next_cycle(); bus.wready = 1'b0;
    mid();
    check("wr1_w_drop_first", 64'(bus.wvalid),  64'(0));
    check("wr1_wdata_zero",   64'(bus.wdata),   64'(0));
    check("wr1_wstrb_zero",   64'(bus.wstrb),   64'(0));
    check("wr1_aw_held",      64'(bus.awvalid), 64'(1));
    next_cycle();
    next_cycle(); bus.awready = 1'b1;
    mid();
    check("wr1_aw_held2", 64'(bus.awvalid), 64'(1));
    next_cycle(); bus.awready = 1'b0;
    mid();
    check("wr1_aw_drop",   64'(bus.awvalid), 64'(0));
    check("wr1_no_bready", 64'(bus.bready),  64'(0));
    next_cycle(); bus.bvalid = 1'b1; bus.bresp = 2'd0;
    mid();
    check("wr1_bready", 64'(bus.bready), 64'(1));
    next_cycle(); bus.bvalid = 1'b0;
    mid();
    check("wr1_rsp_valid",     64'(rsp_valid),     64'(1));
    check("wr1_single_wresp",  64'(bready_cycles), 64'(1));
    next_cycle();

    // rsp_ready held low 5 cycles while a further command is offered
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; bus.arready = 1'b1; rsp_ready = 1'b0;
    push_exp(32'h12345678, 2'd1);
    next_cycle();
    next_cycle(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = 2'd1;
    next_cycle(); bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(32'h12345678));
      check("hold_rsp_resp",  64'(rsp_resp),  64'(1));
      check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      next_cycle();
    end
    rsp_ready = 1'b1;
    next_cycle(); cmd_valid = 1'b0;
    mid();
    check("hold_released", 64'(rsp_valid), 64'(0));
    check("hold_idle",     64'(cmd_ready), 64'(1));

    // arready low for 300 cycles: timeout rises when the stall count reaches TIMEOUT
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; bus.arready = 1'b0;
    push_exp(32'hA5A5A5A5, 2'd0);
    next_cycle(); cmd_valid = 1'b0;
    for (int j = 0; j < 300; j++) begin
      mid();
      if (j == 0 || j == TO - 1 || j == TO || j == 299) begin
        check("to_flag",    64'(timeout),     64'(j >= TO));
        check("to_arvalid", 64'(bus.arvalid), 64'(1));
      end
      next_cycle();
    end
    bus.arready = 1'b1;
    next_cycle(); bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA5A5A5A5; bus.rresp = 2'd0;
    mid();
    check("to_sticky_rdata", 64'(timeout), 64'(1));
    next_cycle(); bus.rvalid = 1'b0; bus.rdata = '0;
    next_cycle();
    mid();
    check("to_sticky_idle", 64'(timeout), 64'(1));

    // Reset in WREQ after AW completes: transaction abandoned, acceptance cleared timeout
    next_cycle();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h55; cmd_wstrb = 4'h1;
    bus.awready = 1'b1; bus.wready = 1'b0;
    next_cycle(); cmd_valid = 1'b0;
    mid();
    check("acc_clears_timeout", 64'(timeout),     64'(0));
    check("rstw_awvalid",       64'(bus.awvalid), 64'(1));
    next_cycle(); bus.awready = 1'b0; areset_n = 1'b0;
    mid();
    check("rstw_aw_done", 64'(bus.awvalid), 64'(0));
    check("rstw_w_wait",  64'(bus.wvalid),  64'(1));
    next_cycle();
    mid();
    check("rstw_wvalid_drop", 64'(bus.wvalid),  64'(0));
    check("rstw_awvalid_low", 64'(bus.awvalid), 64'(0));
    check("rstw_no_rsp",      64'(rsp_valid),   64'(0));
    next_cycle(); areset_n = 1'b1;
    mid();
    check("rstw_cmd_ready", 64'(cmd_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      mid();
      check("rstw_quiet_rsp", 64'(rsp_valid), 64'(0));
    end

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
